// File: rtl/wavegen_pkg.sv
// rtl/wavegen_pkg.sv - shared constants and types for the waveform sequencer
//
// Purpose: opcode values of the SPI command word, the sequencer state
// encoding, the DAC midscale code and the hold counter width.
// Ports:   none (package).
// Config:  WAVEGEN_ONESHOT_EN makes OP_ONESHOT a legal command in
//          wavegen_sequencer; the constant itself is always defined.

package wavegen_pkg;

  localparam logic [3:0] OP_WRITE   = 4'h1;
  localparam logic [3:0] OP_LEN     = 4'h2;
  localparam logic [3:0] OP_DIV     = 4'h3;
  localparam logic [3:0] OP_START   = 4'h4;
  localparam logic [3:0] OP_STOP    = 4'h5;
  localparam logic [3:0] OP_CLRERR  = 4'h6;
  localparam logic [3:0] OP_ONESHOT = 4'h7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam logic [13:0] MIDSCALE = 14'h2000;
  localparam int          HOLD_W   = 14;

endpackage

// File: rtl/wavegen_rate_div.sv
// rtl/wavegen_rate_div.sv - sample hold counter, one tick per sample boundary
//
// Purpose: counts hold = 0..div while enabled and pulses o_tick on the
//          last cycle of each sample; held at zero while disabled.
// Ports:
//   i_clk    in   clock
//   i_rst    in   asynchronous active-high reset
//   i_en     in   count enable (sequencer is priming or running)
//   i_div    in   hold length minus one, in cycles
//   o_tick   out  one-cycle pulse at the end of each sample

module wavegen_rate_div
  import wavegen_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic [HOLD_W-1:0] i_div,
  output logic              o_tick
);

  logic [HOLD_W-1:0] r_hold;
  logic              w_tick;

  // ">=" rather than "==": if div is lowered below the running count,
  // the current sample ends now instead of wrapping the 14-bit counter.
  assign w_tick = i_en && (r_hold >= i_div);
  assign o_tick = w_tick;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hold <= '0;
    end else if (!i_en || w_tick) begin
      r_hold <= '0;
    end else begin
      r_hold <= r_hold + 1'b1;
    end
  end

endmodule

// File: rtl/wavegen_sequencer.sv
// rtl/wavegen_sequencer.sv - SPI command decoder and waveform RAM playback sequencer
//
// Purpose: decodes SPI command words, writes samples into the waveform RAM
//          while idle, and in playback scans RAM[0..last] cyclically, each
//          sample held div+1 cycles, driving the DAC code.
// Ports:
//   i_clk        in   clock
//   i_rst        in   asynchronous active-high reset
//   i_rx_data    in   command word: [31:28] opcode, [27:14] A, [13:0] B
//   i_rx_valid   in   one-cycle strobe qualifying i_rx_data
//   o_mem_we     out  RAM write enable pulse
//   o_mem_waddr  out  RAM write address
//   o_mem_wdata  out  RAM write data
//   o_mem_raddr  out  RAM read address (RAM returns data one cycle later)
//   i_mem_rdata  in   RAM read data
//   o_wd         out  registered DAC code
//   o_state      out  0 = IDLE, 1 = PRIME, 2 = RUN
//   o_err        out  sticky command error
// Config: define WAVEGEN_ONESHOT_EN to enable opcode 0x7 (single pass
//         playback); otherwise opcode 0x7 is illegal.

module wavegen_sequencer
  import wavegen_pkg::*;
#(
  parameter int DEPTH_W = 8,
  parameter int DATA_W  = 14
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [31:0]        i_rx_data,
  input  logic               i_rx_valid,
  output logic               o_mem_we,
  output logic [DEPTH_W-1:0] o_mem_waddr,
  output logic [DATA_W-1:0]  o_mem_wdata,
  output logic [DEPTH_W-1:0] o_mem_raddr,
  input  logic [DATA_W-1:0]  i_mem_rdata,
  output logic [DATA_W-1:0]  o_wd,
  output logic [1:0]         o_state,
  output logic               o_err
);

  state_t             r_state;
  state_t             w_state_next;
  logic               r_mem_we;
  logic [DEPTH_W-1:0] r_mem_waddr;
  logic [DATA_W-1:0]  r_mem_wdata;
  logic [DEPTH_W-1:0] r_mem_raddr;
  logic [DEPTH_W-1:0] r_last;
  logic [HOLD_W-1:0]  r_div;
  logic [DATA_W-1:0]  r_wd;
  logic               r_err;

  logic [3:0]         w_op;
  logic [13:0]        w_arg_a;
  logic [13:0]        w_arg_b;
  logic               w_a_fits;
  logic               w_b_fits;
  logic               w_wr_ok;
  logic               w_len_ok;
  logic               w_div_ld;
  logic               w_start;
  logic               w_stop;
  logic               w_clr;
  logic               w_bad;
  logic               w_tick;
  logic               w_advance;
  logic               w_leave;
  logic               w_draining;
  logic               w_drain_done;
`ifdef WAVEGEN_ONESHOT_EN
  logic               w_oneshot_cmd;
  logic               r_oneshot;
  logic [1:0]         r_drain;
`endif

  assign w_op     = i_rx_data[31:28];
  assign w_arg_a  = i_rx_data[27:14];
  assign w_arg_b  = i_rx_data[13:0];
  assign w_a_fits = (w_arg_a >> DEPTH_W) == 14'd0;
  assign w_b_fits = (w_arg_b >> DEPTH_W) == 14'd0;

  // Command decode; all effects land on the next clock edge.
  always_comb begin
    w_wr_ok  = 1'b0;
    w_len_ok = 1'b0;
    w_div_ld = 1'b0;
    w_start  = 1'b0;
    w_stop   = 1'b0;
    w_clr    = 1'b0;
    w_bad    = 1'b0;
`ifdef WAVEGEN_ONESHOT_EN
    w_oneshot_cmd = 1'b0;
`endif
    if (i_rx_valid) begin
      case (w_op)
        OP_WRITE:  if (r_state == IDLE && w_a_fits) w_wr_ok = 1'b1;
                   else w_bad = 1'b1;
        OP_LEN:    if (r_state == IDLE && w_b_fits) w_len_ok = 1'b1;
                   else w_bad = 1'b1;
        OP_DIV:    w_div_ld = 1'b1;
        OP_START:  w_start = 1'b1;
        OP_STOP:   w_stop = 1'b1;
        OP_CLRERR: w_clr = 1'b1;
`ifdef WAVEGEN_ONESHOT_EN
        OP_ONESHOT: begin
          w_start       = 1'b1;
          w_oneshot_cmd = 1'b1;
        end
`endif
        default:   w_bad = 1'b1;
      endcase
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_start) w_state_next = PRIME;
      PRIME:   w_state_next = w_stop ? IDLE : RUN;
      RUN:     if (w_stop || w_drain_done) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  assign w_leave = (r_state != IDLE) && (w_state_next == IDLE);

  // The counter also runs in PRIME: the read address leads wd by two
  // cycles, so RAM[0] must already be on the bus when RUN begins.
  wavegen_rate_div u_rate_div (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (r_state != IDLE),
    .i_div  (r_div),
    .o_tick (w_tick)
  );

  assign w_advance = (r_state != IDLE) && w_tick && !w_draining;

`ifdef WAVEGEN_ONESHOT_EN
  // The wrap is seen on the read address two cycles before RAM[last] has
  // finished on wd, so a single-pass run drains for two cycles before IDLE.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_oneshot <= 1'b0;
      r_drain   <= 2'd0;
    end else begin
      if (r_state == IDLE && w_start) r_oneshot <= w_oneshot_cmd;
      if (w_leave)
        r_drain <= 2'd0;
      else if (r_drain != 2'd0)
        r_drain <= r_drain - 2'd1;
      else if (r_oneshot && w_advance && r_mem_raddr == r_last)
        r_drain <= 2'd2;
    end
  end
  assign w_draining   = (r_drain != 2'd0);
  assign w_drain_done = (r_drain == 2'd1);
`else
  assign w_draining   = 1'b0;
  assign w_drain_done = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mem_we    <= 1'b0;
      r_mem_waddr <= '0;
      r_mem_wdata <= '0;
      r_mem_raddr <= '0;
      r_last      <= '1;
      r_div       <= '0;
      r_wd        <= DATA_W'(MIDSCALE);
      r_err       <= 1'b0;
    end else begin
      r_mem_we <= w_wr_ok;
      if (w_wr_ok) begin
        r_mem_waddr <= w_arg_a[DEPTH_W-1:0];
        r_mem_wdata <= w_arg_b[DATA_W-1:0];
      end
      if (w_len_ok) r_last <= w_arg_b[DEPTH_W-1:0];
      if (w_div_ld) r_div  <= w_arg_b;

      // A new error outranks a clear on the same strobe.
      if (w_bad)      r_err <= 1'b1;
      else if (w_clr) r_err <= 1'b0;

      if (r_state == IDLE && w_state_next == PRIME)
        r_mem_raddr <= '0;
      else if (w_advance)
        r_mem_raddr <= (r_mem_raddr == r_last) ? '0 : r_mem_raddr + 1'b1;

      if (w_leave)
        r_wd <= DATA_W'(MIDSCALE);
      else if (r_state == RUN)
        r_wd <= i_mem_rdata;
    end
  end

  assign o_mem_we    = r_mem_we;
  assign o_mem_waddr = r_mem_waddr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_mem_raddr = r_mem_raddr;
  assign o_wd        = r_wd;
  assign o_state     = r_state;
  assign o_err       = r_err;

endmodule

// File: tb/tb_wavegen_sequencer.sv
// tb/tb_wavegen_sequencer.sv - scoreboard bench for wavegen_sequencer

module tb_wavegen_sequencer;
  import wavegen_pkg::*;

  localparam logic [13:0] MID = 14'h2000;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [31:0] i_rx_data;
  logic        i_rx_valid;
  logic        o_mem_we;
  logic [7:0]  o_mem_waddr;
  logic [13:0] o_mem_wdata;
  logic [7:0]  o_mem_raddr;
  logic [13:0] i_mem_rdata;
  logic [13:0] o_wd;
  logic [1:0]  o_state;
  logic        o_err;

  wavegen_sequencer #(.DEPTH_W(8), .DATA_W(14)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_rx_data   (i_rx_data),
    .i_rx_valid  (i_rx_valid),
    .o_mem_we    (o_mem_we),
    .o_mem_waddr (o_mem_waddr),
    .o_mem_wdata (o_mem_wdata),
    .o_mem_raddr (o_mem_raddr),
    .i_mem_rdata (i_mem_rdata),
    .o_wd        (o_wd),
    .o_state     (o_state),
    .o_err       (o_err)
  );

  always #5 i_clk = ~i_clk;

  // Synchronous waveform RAM.
  logic [13:0] ram [0:255];
  always @(posedge i_clk) begin
    if (o_mem_we) ram[o_mem_waddr] <= o_mem_wdata;
    i_mem_rdata <= ram[o_mem_raddr];
  end

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [21:0] exp_wr [$];
  logic [13:0] exp_wd [$];
  logic [1:0]  prev_state = 2'd0;

  // Monitor: a write pulse pops a write expectation; every cycle following
  // a RUN cycle presents a DAC sample and pops a wd expectation.
  always @(negedge i_clk) begin
    logic [21:0] ew;
    logic [13:0] ed;
    if (o_mem_we) begin
      n_cmp++;
      if (exp_wr.size() == 0) begin
        n_bad++;
        $display("FAIL wr_unexpected: got addr=%0d data=0x%0h, required no write", o_mem_waddr, o_mem_wdata);
      end else begin
        ew = exp_wr.pop_front();
        if ({o_mem_waddr, o_mem_wdata} !== ew) begin
          n_bad++;
          $display("FAIL wr_data: got addr=%0d data=0x%0h, required addr=%0d data=0x%0h",
                   o_mem_waddr, o_mem_wdata, ew[21:14], ew[13:0]);
        end
      end
    end
    if (prev_state == 2'd2) begin
      n_cmp++;
      if (exp_wd.size() == 0) begin
        n_bad++;
        $display("FAIL wd_unexpected: got wd=0x%0h, required no sample", o_wd);
      end else begin
        ed = exp_wd.pop_front();
        if (o_wd !== ed) begin
          n_bad++;
          $display("FAIL wd_sample: got wd=0x%0h, required 0x%0h at t=%0t", o_wd, ed, $time);
        end
      end
    end
    prev_state = o_state;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [3:0] op, input logic [13:0] a, input logic [13:0] b);
    i_rx_data  = {op, a, b};
    i_rx_valid = 1'b1;
    @(posedge i_clk);
    #1;
    i_rx_valid = 1'b0;
    i_rx_data  = '0;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic push_rep(input logic [13:0] v, input int n);
    for (int k = 0; k < n; k++) exp_wd.push_back(v);
  endtask

  initial begin
    i_rst      = 1'b1;
    i_rx_valid = 1'b0;
    i_rx_data  = '0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_state", 32'(o_state), 32'd0);
    chk("rst_err",   32'(o_err),   32'd0);
    chk("rst_wd",    32'(o_wd),    32'(MID));
    chk("rst_we",    32'(o_mem_we), 32'd0);
    chk("rst_raddr", 32'(o_mem_raddr), 32'd0);
    chk("rst_waddr", 32'(o_mem_waddr), 32'd0);
    chk("rst_wdata", 32'(o_mem_wdata), 32'd0);
    i_rst = 1'b0;
    cycles(1);

    // Write accepted, then out-of-range address rejected.
    exp_wr.push_back({8'd5, 14'h1ABC});
    send(OP_WRITE, 14'd5, 14'h1ABC);
    send(OP_WRITE, 14'h100, 14'd1);
    chk("wr_oob_err", 32'(o_err), 32'd1);
    send(OP_CLRERR, 14'd0, 14'd0);
    chk("clrerr_1", 32'(o_err), 32'd0);

    for (int i = 0; i < 4; i++) begin
      exp_wr.push_back({8'(i), 14'(10 * (i + 1))});
      send(OP_WRITE, 14'(i), 14'(10 * (i + 1)));
    end

    // LEN boundary: 255 legal, 256 rejected without changing last.
    send(OP_LEN, 14'd0, 14'd255);
    chk("len_255_ok", 32'(o_err), 32'd0);
    send(OP_LEN, 14'd0, 14'd3);
    send(OP_LEN, 14'd0, 14'd256);
    chk("len_256_err", 32'(o_err), 32'd1);
    send(OP_CLRERR, 14'd0, 14'd0);
    chk("clrerr_2", 32'(o_err), 32'd0);
    send(OP_DIV, 14'd0, 14'd0);

    // Playback at div=0, DIV 2 mid-run, then STOP.
    exp_wd.push_back(14'd10); exp_wd.push_back(14'd20); exp_wd.push_back(14'd30);
    exp_wd.push_back(14'd40); exp_wd.push_back(14'd10); exp_wd.push_back(14'd20);
    push_rep(14'd30, 3);
    push_rep(14'd40, 3);
    push_rep(14'd10, 3);
    push_rep(14'd20, 3);
    exp_wd.push_back(MID);
    send(OP_START, 14'd0, 14'd0);                 // cycle n
    chk("start_prime", 32'(o_state), 32'd1);
    chk("start_raddr", 32'(o_mem_raddr), 32'd0);
    cycles(1);
    chk("start_run", 32'(o_state), 32'd2);
    cycles(4);
    send(OP_DIV, 14'd0, 14'd2);                   // cycle n+6
    send(OP_WRITE, 14'd7, 14'd99);                // cycle n+7, rejected
    chk("wr_in_run_err", 32'(o_err), 32'd1);
    send(OP_CLRERR, 14'd0, 14'd0);
    chk("clrerr_3", 32'(o_err), 32'd0);
    send(OP_START, 14'd0, 14'd0);                 // ignored in RUN
    chk("restart_noerr", 32'(o_err), 32'd0);
    chk("restart_state", 32'(o_state), 32'd2);
    cycles(10);
    send(OP_STOP, 14'd0, 14'd0);                  // cycle n+20
    chk("stop_state", 32'(o_state), 32'd0);
    chk("stop_wd", 32'(o_wd), 32'(MID));

    // Illegal opcode, then asynchronous reset mid-run.
    send(OP_DIV, 14'd0, 14'd0);
    send(4'hF, 14'd0, 14'd0);
    chk("bad_op_err", 32'(o_err), 32'd1);
    exp_wd.push_back(14'd10);
    exp_wd.push_back(MID);
    send(OP_START, 14'd0, 14'd0);
    cycles(3);
    i_rst = 1'b1;
    #1;
    chk("arst_state", 32'(o_state), 32'd0);
    chk("arst_wd",    32'(o_wd),    32'(MID));
    chk("arst_raddr", 32'(o_mem_raddr), 32'd0);
    chk("arst_err",   32'(o_err),   32'd0);
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    cycles(1);

`ifdef WAVEGEN_ONESHOT_EN
    send(OP_LEN, 14'd0, 14'd3);
    exp_wd.push_back(14'd10); exp_wd.push_back(14'd20);
    exp_wd.push_back(14'd30); exp_wd.push_back(14'd40);
    exp_wd.push_back(MID);
    send(OP_ONESHOT, 14'd0, 14'd0);
    chk("oneshot_prime", 32'(o_state), 32'd1);
    cycles(6);
    chk("oneshot_idle", 32'(o_state), 32'd0);
    chk("oneshot_wd", 32'(o_wd), 32'(MID));
    cycles(3);
    chk("oneshot_stays", 32'(o_state), 32'd0);
`else
    send(OP_ONESHOT, 14'd0, 14'd0);
    chk("op7_err", 32'(o_err), 32'd1);
    chk("op7_state", 32'(o_state), 32'd0);
`endif

    cycles(3);
    chk("wr_queue_drained", 32'(exp_wr.size()), 32'd0);
    chk("wd_queue_drained", 32'(exp_wd.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wavegen_sequencer.md
# wavegen_sequencer

Command decoder and playback sequencer for the arbitrary-waveform path, placed between the SPI slave receive word stream and the AD9744 DAC. It writes decoded sample commands into the waveform RAM, holds the playback length and rate, and during playback scans the RAM cyclically to drive the DAC code `wd`. It is the only owner of both RAM ports: host writes are allowed only while idle, so writes and playback reads never contend.

## Interface
- `DEPTH_W`, 8: RAM address width. Depth is 2^DEPTH_W entries.
- `DATA_W`, 14: sample width, matching the AD9744 code width.
- `clk`  in  1  system clock; all logic is synchronous to it.
- `rst`  in  1  reset, asynchronous and active-high.
- `rx_data`  in  32  SPI word: `[31:28]` opcode, `[27:14]` argument A, `[13:0]` argument B.
- `rx_valid`  in  1  one-cycle strobe; `rx_data` is valid in the same cycle.
- `mem_we`  out  1  RAM write enable, one-cycle pulse.
- `mem_waddr`  out  DEPTH_W  RAM write address.
- `mem_wdata`  out  DATA_W  RAM write data.
- `mem_raddr`  out  DEPTH_W  RAM read address. The RAM is synchronous, so read data arrives 1 cycle later.
- `mem_rdata`  in  DATA_W  RAM read data.
- `wd`  out  DATA_W  DAC code, registered.
- `state`  out  2  current state: 0 = IDLE, 1 = PRIME, 2 = RUN.
- `err`  out  1  sticky command error.

## Operation
- Opcodes:
  - 0x1 WRITE: writes B to address A.
  - 0x2 LEN: sets `last` = B.
  - 0x3 DIV: sets `div` = B.
  - 0x4 START.
  - 0x5 STOP.
  - 0x6 CLRERR.
  - 0x7 ONESHOT, only when the macro below is defined.
  - Any other opcode sets `err`.
- WRITE:
  - Accepted only in IDLE with A < 2^DEPTH_W.
  - Drives `mem_we`=1, `mem_waddr`=A[DEPTH_W-1:0], `mem_wdata`=B for exactly 1 cycle, starting the cycle after `rx_valid`.
  - Otherwise no write and `err` is set.
- LEN:
  - Accepted only in IDLE with B ≤ 2^DEPTH_W−1.
  - Otherwise `last` is unchanged and `err` is set.
- DIV: accepted in any state. In RUN, the new value is used from the next sample boundary.
- State machine:
  - IDLE to PRIME on START: `mem_raddr` ← 0.
  - PRIME to RUN after 1 cycle.
  - RUN: a 14-bit `hold` counter counts 0..`div`. When `hold`==`div`, `hold` ← 0 and `mem_raddr` ← (`mem_raddr`==`last`) ? 0 : `mem_raddr`+1. Each sample is therefore held `div`+1 cycles.
  - STOP in PRIME or RUN returns to IDLE. `wd` ← 14'h2000 (DAC midscale) on the next edge.
  - START while in PRIME or RUN is ignored and does not set `err`.
- `wd` ← `mem_rdata` on every cycle in RUN.
- CLRERR clears `err`. If CLRERR and a new error occur on the same strobe, the error wins. This cannot happen with a single word per strobe.
- Reset values:
  - `state` = IDLE, `err` = 0.
  - `wd` = 14'h2000, `mem_we` = 0.
  - `mem_waddr`, `mem_wdata`, `mem_raddr` = 0.
  - `last` = 2^DEPTH_W−1, `div` = 0, `hold` = 0.
- Reset in mid-playback forces all of the above immediately. RAM contents are untouched.

## Timing
- Command decode latency: 1 cycle from the `rx_valid` edge to the register update or `mem_we` pulse.
- START at cycle n gives:
  - `state`=PRIME at n+1, with `mem_raddr`=0.
  - `state`=RUN at n+2.
  - `wd`=RAM[0] at n+3.
- From `mem_raddr` change to `wd` is 2 cycles: 1 cycle RAM latency plus 1 cycle `wd` register.
- With `div`=0, the address advances every cycle and `wd` follows every cycle.
- Wrap: the RAM[`last`] sample is followed directly by RAM[0], with no gap cycle.
- `rx_valid` on consecutive cycles: each word is processed in order. No back-pressure; the SPI slave cannot exceed 1 word per 32 SCK periods.

## Configuration
- `WAVEGEN_ONESHOT_EN` defined:
  - Opcode 0x7 ONESHOT behaves as START, but the first wrap (the `hold`==`div` boundary at `mem_raddr`==`last`) ends playback instead.
  - At that point the block goes to IDLE and `wd` ← 14'h2000.
- `WAVEGEN_ONESHOT_EN` undefined: opcode 0x7 is illegal and sets `err`.

## Structure
- A shared package `wavegen_pkg` holds:
  - The opcode constants OP_WRITE..OP_ONESHOT.
  - The state encoding IDLE/PRIME/RUN.
  - The midscale constant 14'h2000.
- Sub-module `wavegen_rate_div` holds the `hold` counter. It takes `div` and `en` and outputs a one-cycle `tick`. Everything else lives in `wavegen_sequencer`.

## Test plan
- Write test: words 0x1_0005_1ABC, then 0x1_0100_0001 with DEPTH_W=8 → one `mem_we` pulse with addr 5, data 0x1ABC; second word → no write and `err`=1.
- Playback: write RAM[0..3]=10,20,30,40, LEN 3, DIV 0, START → `wd` = 10,20,30,40,10,20… from START+3 cycles, no gap cycle at the wrap.
- Rate: DIV 2 during RUN → each value held 3 cycles starting at the next boundary. WRITE during RUN → no `mem_we`, `err`=1. CLRERR → `err`=0.
- STOP mid-run → IDLE next cycle, `wd`=0x2000. Assert `rst` mid-run → outputs take their reset values asynchronously, before the next clock edge.
- With `WAVEGEN_ONESHOT_EN`, LEN 3 then ONESHOT → exactly one pass 10,20,30,40, then IDLE and `wd`=0x2000. Without the macro, opcode 0x7 → `err`=1.
